// File: rtl/pkt_rx_checker.sv
// pkt_rx_checker: sop/vld/eop/len beat checker with violation classes and counters.
// Optional build macro PKT_GAP_CHECK_EN: a vld gap inside a packet is a violation.
module pkt_rx_checker #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sop,
    input  logic             vld,
    input  logic             eop,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_len,
    output logic             err,
    output logic [5:0]       err_code,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {IDLE, BODY} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] beat_cnt, cnt_n;
    logic [LEN_W-1:0] nb, lim;
    logic             open_sop, pkt_beat, hit;
    logic             done_n;
    logic [5:0]       code_n;

    // A sop beat always restarts counting at 1 against the new length.
    assign open_sop = vld & sop & (len != '0);
    assign nb       = (vld & sop) ? LEN_W'(1) : beat_cnt + LEN_W'(1);
    assign lim      = sop ? len : len_q;
    assign pkt_beat = open_sop | (vld & ~sop & (state == BODY));
    assign hit      = (nb == lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            len_q    <= len_n;
            beat_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len_q;
        cnt_n   = beat_cnt;
        if (open_sop)
            len_n = len;
        if (pkt_beat) begin
            if (eop || hit) begin
                state_n = IDLE;
            end else begin
                state_n = BODY;
                cnt_n   = nb;
            end
        end else if (vld) begin
            state_n = IDLE;
        end else begin
`ifdef PKT_GAP_CHECK_EN
            state_n = IDLE;
`else
            state_n = state;
`endif
        end
    end

    always_comb begin
        code_n    = '0;
        code_n[0] = (state == BODY) & vld & sop;
        code_n[1] = pkt_beat & eop & ~hit;
        code_n[2] = pkt_beat & ~eop & hit;
        code_n[3] = (state == IDLE) & vld & ~sop;
        code_n[4] = vld & sop & (len == '0);
`ifdef PKT_GAP_CHECK_EN
        code_n[5] = (state == BODY) & ~vld;
`else
        code_n[5] = 1'b0;
`endif
        // An aborted packet's error wins over a same-beat len=1 completion.
        done_n = pkt_beat & eop & hit & ~code_n[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_done <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            pkt_done <= done_n;
            err      <= |code_n;
            err_code <= code_n;
            if (done_n && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            if ((|code_n) && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign busy    = (state == BODY);
    assign pkt_len = len_q;

endmodule

// File: tb/tb_pkt_rx_checker.sv
// tb_pkt_rx_checker: directed scenarios plus a randomized beat stream
// checked against a packet-level reference model.
module tb_pkt_rx_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        sop, vld, eop;
    logic [3:0]  len;
    logic        busy, pkt_done, err;
    logic [3:0]  pkt_len;
    logic [5:0]  err_code;
    logic [15:0] pkt_cnt, err_cnt;

`ifdef PKT_GAP_CHECK_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    pkt_rx_checker dut (
        .clk(clk), .rst(rst), .sop(sop), .vld(vld), .eop(eop), .len(len),
        .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len), .err(err),
        .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: packet-level view
    bit          m_open;
    int          m_len, m_seen;
    logic        e_busy, e_done, e_err;
    logic [5:0]  e_code;
    logic [3:0]  e_pkt_len;
    logic [15:0] e_pcnt, e_ecnt;

    typedef struct packed {
        logic       s;
        logic       v;
        logic       e;
        logic [3:0] l;
    } beat_t;

    task automatic model_reset();
        m_open = 0; m_len = 0; m_seen = 0;
        e_busy = 0; e_done = 0; e_err = 0; e_code = '0;
        e_pkt_len = '0; e_pcnt = '0; e_ecnt = '0;
    endtask

    task automatic model_beat(input logic s, input logic v,
                              input logic e, input logic [3:0] l);
        logic [5:0] code;
        bit done;
        code = '0;
        done = 0;
        if (!v) begin
            if (m_open && GAP) begin
                code[5] = 1;
                m_open = 0;
            end
        end else begin
            if (s) begin
                if (m_open) begin
                    code[0] = 1;
                    m_open = 0;
                end
                if (l == 0) begin
                    code[4] = 1;
                end else begin
                    m_open = 1;
                    m_len = int'(l);
                    m_seen = 0;
                    e_pkt_len = l;
                end
            end else if (!m_open) begin
                code[3] = 1;
            end
            if (m_open) begin
                m_seen++;
                if (e) begin
                    if (m_seen == m_len) done = 1;
                    else code[1] = 1;
                    m_open = 0;
                end else if (m_seen == m_len) begin
                    code[2] = 1;
                    m_open = 0;
                end
            end
        end
        if (code != 0) done = 0;
        e_done = done;
        e_err = (code != 0);
        e_code = code;
        e_busy = m_open;
        if (done && e_pcnt != 16'hFFFF) e_pcnt++;
        if (code != 0 && e_ecnt != 16'hFFFF) e_ecnt++;
    endtask

    task automatic step(input logic s, input logic v,
                        input logic e, input logic [3:0] l);
        sop = s; vld = v; eop = e; len = l;
        model_beat(s, v, e, l);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; sop = 0; vld = 0; eop = 0; len = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, pkt_done, err, err_code, pkt_len, pkt_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b done=%b err=%b code=%b len=%0d pc=%0d ec=%0d, want all 0",
                     busy, pkt_done, err, err_code, pkt_len, pkt_cnt, err_cnt);
        end
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        step(1, 1, 0, 5);
        n_vec++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_open: got busy=%b err=%b, want 1 0", busy, err);
        end
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n_vec++;
        if (pkt_done !== 1'b1 || pkt_len !== 4'd5 || pkt_cnt !== 16'd1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_done: got done=%b len=%0d pc=%0d err=%b, want 1 5 1 0",
                     pkt_done, pkt_len, pkt_cnt, err);
        end
        step(0, 0, 0, 0);
        n_vec++;
        if (pkt_done !== 1'b0 || busy !== 1'b0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL t1_after: got done=%b busy=%b ec=%0d, want 0 0 0",
                     pkt_done, busy, err_cnt);
        end
    endtask

    task automatic test_len1();
        step(1, 1, 1, 1);
        n_vec++;
        if (pkt_done !== 1'b1 || busy !== 1'b0 || pkt_len !== 4'd1 || pkt_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL t2_len1: got done=%b busy=%b len=%0d pc=%0d, want 1 0 1 2",
                     pkt_done, busy, pkt_len, pkt_cnt);
        end
    endtask

    task automatic test_missing_orphan();
        step(1, 1, 0, 1);
        n_vec++;
        if (err !== 1'b1 || err_code !== 6'b000100 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t3_missing: got err=%b code=%b busy=%b, want 1 000100 0",
                     err, err_code, busy);
        end
        step(0, 1, 1, 0);
        n_vec++;
        if (err_code !== 6'b001000 || err_cnt !== 16'd2 || pkt_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL t3_orphan: got code=%b ec=%0d pc=%0d, want 001000 2 2",
                     err_code, err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_sop_in_pkt();
        step(1, 1, 0, 5);
        step(0, 1, 0, 0);
        step(1, 1, 0, 3);
        n_vec++;
        if (err_code !== 6'b000001 || busy !== 1'b1 || pkt_len !== 4'd3) begin
            n_bad++;
            $display("FAIL t4_sop: got code=%b busy=%b len=%0d, want 000001 1 3",
                     err_code, busy, pkt_len);
        end
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n_vec++;
        if (pkt_done !== 1'b1 || pkt_len !== 4'd3 || pkt_cnt !== 16'd3 || err_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL t4_done: got done=%b len=%0d pc=%0d ec=%0d, want 1 3 3 3",
                     pkt_done, pkt_len, pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 5);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        sop = 0; vld = 0; eop = 0; len = 0;
        rst = 1;
        model_reset();
        #1;
        n_vec++;
        if ({busy, pkt_done, err, err_code, pkt_len, pkt_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL t5_async: got busy=%b len=%0d pc=%0d ec=%0d, want 0",
                     busy, pkt_len, pkt_cnt, err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 0;
        step(1, 1, 0, 2);
        n_vec++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_open: got busy=%b err=%b, want 1 0", busy, err);
        end
        step(0, 1, 1, 0);
        n_vec++;
        if (pkt_done !== 1'b1 || pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL t5_done: got done=%b pc=%0d ec=%0d, want 1 1 0",
                     pkt_done, pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_gap();
        step(1, 1, 0, 4);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        n_vec++;
        if (GAP ? (err_code !== 6'b100000 || busy !== 1'b0)
                : (err !== 1'b0 || busy !== 1'b1)) begin
            n_bad++;
            $display("FAIL t6_gap: got code=%b busy=%b (gap check %0d)", err_code, busy, GAP);
        end
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n_vec++;
        if (GAP ? (err_code !== 6'b001000 || pkt_cnt !== 16'd1 || err_cnt !== 16'd3)
                : (pkt_done !== 1'b1 || pkt_cnt !== 16'd2 || err_cnt !== 16'd0)) begin
            n_bad++;
            $display("FAIL t6_end: got done=%b code=%b pc=%0d ec=%0d (gap check %0d)",
                     pkt_done, err_code, pkt_cnt, err_cnt, GAP);
        end
    endtask

    task automatic test_random();
        beat_t q[$];
        for (int k = 0; k < 300; k++) begin
            int L, nbeats;
            L = ($urandom % 10 == 0) ? 15 : int'($urandom_range(0, 5));
            nbeats = (L == 0) ? 1 : L;
            for (int b = 1; b <= nbeats; b++) begin
                beat_t t;
                t.v = 1'b1;
                t.s = (b == 1);
                t.e = (b == nbeats);
                t.l = t.s ? 4'(L) : 4'($urandom);
                if ($urandom % 16 == 0) t.e = ~t.e;
                if ($urandom % 20 == 0) t.s = 1'b1;
                if ($urandom % 12 == 0)
                    q.push_back('{s: 1'($urandom), v: 1'b0, e: 1'($urandom), l: 4'($urandom)});
                q.push_back(t);
            end
        end
        foreach (q[i]) begin
            step(q[i].s, q[i].v, q[i].e, q[i].l);
            n_vec++;
            if ({busy, pkt_done, err, err_code, pkt_len, pkt_cnt, err_cnt} !==
                {e_busy, e_done, e_err, e_code, e_pkt_len, e_pcnt, e_ecnt}) begin
                n_bad++;
                $display("FAIL rand[%0d]: got busy=%b done=%b err=%b code=%b len=%0d pc=%0d ec=%0d; want %b %b %b %b %0d %0d %0d",
                         i, busy, pkt_done, err, err_code, pkt_len, pkt_cnt, err_cnt,
                         e_busy, e_done, e_err, e_code, e_pkt_len, e_pcnt, e_ecnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len1();
        test_missing_orphan();
        test_sop_in_pkt();
        test_reset_mid();
        test_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
